mul_iter_ctrl: RTL and testbench

Iterative unsigned multiplier controller that time-shares one `csa_tree` instance (NUM_TERMS = 12) across several passes to form a full 2·DATA_WIDTH-bit product. Each pass feeds up to 10 shifted partial products plus the running carry-save pair back into the tree. A final carry-propagate add resolves the product. It sits between the issue logic (valid/ready request) and the result writeback (valid/ready response) in the Multiplier block.

---
 rtl/mul_iter_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mul_iter_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_iter_ctrl.sv
// ============================================================================
// Module   : mul_iter_ctrl (with helper csa_tree)
// Purpose  : Iterative unsigned multiplier that reuses one 12-term carry-save
//            tree across passes of 10 partial products each.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csa_tree #(
    parameter int NUM_TERMS  = 12,
    parameter int DATA_WIDTH = 128
) (
    input  logic [NUM_TERMS-1:0][DATA_WIDTH-1:0] terms,
    output logic [DATA_WIDTH-1:0]                sum,
    output logic [DATA_WIDTH-1:0]                carry
);
    logic [NUM_TERMS-2:0][DATA_WIDTH-1:0] w_s;
    logic [NUM_TERMS-2:0][DATA_WIDTH-1:0] w_c;

    assign w_s[0] = terms[0];
    assign w_c[0] = terms[1];

    // Each 3:2 stage folds one more term into the running redundant pair.
    for (genvar i = 1; i < NUM_TERMS - 1; i++) begin : g_csa
        logic [DATA_WIDTH-1:0] w_maj;
        assign w_maj  = (w_s[i-1] & w_c[i-1]) | (w_s[i-1] & terms[i+1]) | (w_c[i-1] & terms[i+1]);
        assign w_s[i] = w_s[i-1] ^ w_c[i-1] ^ terms[i+1];
        assign w_c[i] = {w_maj[DATA_WIDTH-2:0], 1'b0};
    end

    assign sum   = w_s[NUM_TERMS-2];
    assign carry = w_c[NUM_TERMS-2];
endmodule

module mul_iter_ctrl #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] product,
    output logic                    busy
);
    localparam int PP_PER_PASS = 10;
    localparam int NUM_TERMS   = PP_PER_PASS + 2;
    localparam int NUM_PASSES  = (DATA_WIDTH + PP_PER_PASS - 1) / PP_PER_PASS;
    localparam int PW          = 2 * DATA_WIDTH;
    localparam int CNT_W       = $clog2(NUM_PASSES + 1);
    localparam int SH_W        = $clog2(PW) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_ADD  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [PW-1:0]         acc_s_q, acc_s_d;
    logic [PW-1:0]         acc_c_q, acc_c_d;
    logic [PW-1:0]         product_q, product_d;
    logic [DATA_WIDTH-1:0] a_reg_q, a_reg_d;
    logic [DATA_WIDTH-1:0] b_rem_q, b_rem_d;
    logic [CNT_W-1:0]      pass_cnt_q, pass_cnt_d;
    logic                  out_valid_q, out_valid_d;

    logic [NUM_TERMS-1:0][PW-1:0] w_terms;
    logic [PW-1:0]                w_tree_s, w_tree_c;
    logic [SH_W-1:0]              w_base;
    logic [DATA_WIDTH-1:0]        w_b_next;
    logic                         w_accept, w_last_pass;

    assign w_base      = SH_W'(pass_cnt_q) * SH_W'(PP_PER_PASS);
    assign w_b_next    = b_rem_q >> PP_PER_PASS;
    assign w_last_pass = (w_b_next == '0) || (pass_cnt_q == CNT_W'(NUM_PASSES - 1));
    assign w_accept    = in_valid && in_ready;

    for (genvar j = 0; j < PP_PER_PASS; j++) begin : g_pp
        assign w_terms[j] = b_rem_q[j] ? (PW'(a_reg_q) << (w_base + SH_W'(j))) : '0;
    end
    assign w_terms[NUM_TERMS-2] = acc_s_q;
    assign w_terms[NUM_TERMS-1] = acc_c_q;

    csa_tree #(
        .NUM_TERMS  (NUM_TERMS),
        .DATA_WIDTH (PW)
    ) u_tree (
        .terms (w_terms),
        .sum   (w_tree_s),
        .carry (w_tree_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (w_accept) state_d = S_RUN;
            S_RUN:  if (w_last_pass) state_d = S_ADD;
            S_ADD:  state_d = S_HOLD;
            S_HOLD: if (out_ready) state_d = w_accept ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
        busy      = (state_q == S_RUN) || (state_q == S_ADD);
        out_valid = out_valid_q;
        product   = product_q;
    end

    always_comb begin
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        product_d   = product_q;
        a_reg_d     = a_reg_q;
        b_rem_d     = b_rem_q;
        pass_cnt_d  = pass_cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_RUN: begin
                acc_s_d    = w_tree_s;
                acc_c_d    = w_tree_c;
                b_rem_d    = w_b_next;
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
            S_ADD: begin
                product_d   = acc_s_q + acc_c_q;
                out_valid_d = 1'b1;
            end
            S_HOLD: if (out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
        // Accept only happens in IDLE/HOLD, so it never collides with a pass.
        if (w_accept) begin
            a_reg_d    = a;
            b_rem_d    = b;
            acc_s_d    = '0;
            acc_c_d    = '0;
            pass_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            product_q   <= '0;
            a_reg_q     <= '0;
            b_rem_q     <= '0;
            pass_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            product_q   <= product_d;
            a_reg_q     <= a_reg_d;
            b_rem_q     <= b_rem_d;
            pass_cnt_q  <= pass_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_mul_iter_ctrl.sv
// ============================================================================
// Module   : tb_mul_iter_ctrl
// Purpose  : Scoreboard bench for mul_iter_ctrl (product and latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_iter_ctrl;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   a;
    logic [63:0]   b;
    logic          out_valid;
    logic          out_ready;
    logic [127:0]  product;
    logic          busy;

    typedef struct {
        logic [127:0] prod;
        int           acc_edge;
        int           p;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_cnt = 0;
    int   ov_edge  = 0;
    bit   ov_seen  = 1'b0;
    bit   rnd_done = 1'b0;

    mul_iter_ctrl #(.DATA_WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int passes(input logic [63:0] bv);
        int n = 0;
        for (int i = 0; i < 64; i++) if (bv[i]) n = i + 1;
        return (n == 0) ? 1 : (n + 9) / 10;
    endfunction

    // Monitor: retire before push so a back-to-back HOLD handshake works.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            ov_seen = 1'b0;
        end else begin
            if (out_valid && !ov_seen) begin
                ov_seen = 1'b1;
                ov_edge = edge_cnt;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 128'(out_valid), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("product", product, e.prod);
                    check("latency", 128'(ov_edge - e.acc_edge), 128'(e.p + 1));
                end
                ov_seen = 1'b0;
            end
            if (in_valid && in_ready) begin
                e.prod     = 128'(a) * 128'(b);
                e.acc_edge = edge_cnt + 1;
                e.p        = passes(b);
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [63:0] ta, input logic [63:0] tb);
        int t = 0;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("send_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", 128'(sb.size()), 128'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_product", product, 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(64'd3, 64'd5);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("busy_cycles", 128'(cnt), 128'(2));
        drain();

        send('1, '1);
        drain();
        send(64'h1234, 64'd0);
        drain();
        send(64'd1, 64'h8000_0000_0000_0000);
        drain();

        out_ready = 1'b0;
        send(64'd7, 64'd9);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_product", product, 128'd63);
            check("bp_out_valid", 128'(out_valid), 128'(1));
            check("bp_in_ready", 128'(in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("b2b_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        send(64'd2, 64'd3);
        drain();

        send('1, '1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_busy", 128'(busy), 128'(0));
        check("arst_product", product, 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("post_rst_no_valid", 128'(cnt), 128'(0));
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_product", product, 128'(0));
        @(posedge clk);
        #1;
        send(64'd4, 64'd4);
        drain();

        fork
            begin
                for (int n = 0; n < 3000; n++) begin
                    logic [63:0] ra, rb;
                    ra = {$urandom, $urandom} >> $urandom_range(0, 63);
                    rb = {$urandom, $urandom} >> $urandom_range(0, 64);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(ra, rb);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
